ether_rx_frame_buf: RTL and testbench
=====================================

ETHER_RX_FRAME_BUF -- requirements
Module: ether_rx_frame_buf

Interface
REQ-001 Parameters:
- LOCAL_MAC, 48'h0000_0000_0000, unicast address accepted, compared against the raw des_mac bus value.
- PROMISC, 0, when 1 accept every destination.
- ADDR_W, 9, data buffer depth = 2^ADDR_W 32-bit words.
REQ-002 Ports (name, direction, width, meaning):
- rx_clk  in  1  sole clock.
- rst  in  1  reset; synchronous and active-high.
- start_flag  in  1  one-cycle pulse marking frame start (SFD seen).
- des_mac_valid  in  1  des_mac qualifier pulse.
- des_mac  in  48  destination MAC.
- len_type_valid  in  1  len_type qualifier pulse.
- len_type  in  16  length/type field.
- data_valid  in  1  one-cycle word-strobe.
- data  in  32  frame word.
- done_flag  in  1  one-cycle end-of-frame pulse.
- out_valid  out  1  out_data holds a committed word.
- out_ready  in  1  consumer accepts the word when high with out_valid.
- out_data  out  32  frame word.
- out_first  out  1  word is the first of its frame.
- out_last  out  1  word is the last of its frame.
- out_len  out  16  len_type of the current output frame, stable for the whole frame.
- drop_cnt  out  16  count of dropped frames, saturating.

Function
REQ-003 Write side states: IDLE, FILL, DISCARD.
REQ-004 IDLE: start_flag -> FILL if the length FIFO has a free slot, else DISCARD with drop_cnt+1.
REQ-005 FILL: every data_valid writes data at wr_ptr and increments wr_ptr (mod 2^ADDR_W) and a frame word count.
REQ-006 des_mac_valid in FILL: if not (des_mac==LOCAL_MAC, or des_mac==48'hFFFF_FFFF_FFFF, or PROMISC==1) -> DISCARD; wr_ptr rolls back to the committed pointer next cycle; drop_cnt+1.
REQ-007 len_type_valid in FILL latches len_type for the frame record.
REQ-008 Overflow: a data_valid while free words==0 (wr_ptr+1==rd_ptr) is not written; state -> DISCARD with rollback; drop_cnt+1.
REQ-009 done_flag in FILL with word count>0 commits the frame:
- Record {word count, len_type} is pushed into a 4-entry length FIFO.
- Committed pointer <= wr_ptr on the next cycle.
- State -> IDLE.
REQ-010 done_flag in FILL with word count 0: rollback, no commit, no drop count.
REQ-011 done_flag in DISCARD -> IDLE.
REQ-012 done_flag in IDLE is ignored.
REQ-013 start_flag in FILL (missed done): discard the partial frame by rolling back, drop_cnt+1, restart per REQ-004 in the same cycle.
REQ-014 start_flag in DISCARD: treated as in IDLE.
REQ-015 drop_cnt saturates at 16'hFFFF.
REQ-016 Read side: when the length FIFO is non-empty, words are streamed from rd_ptr in order.
- out_data, out_first, out_last, out_len are registered.
- out_valid is not asserted earlier than 2 cycles after the committing done_flag.
- A word transfers when out_valid & out_ready.
- After a transfer, the next word of a frame is presented no later than the following cycle (1 word/cycle sustained).
REQ-017 out_valid holds, and out_data/out_first/out_last/out_len stay stable, while out_ready is low.
REQ-018 out_last marks word number (word count) of the frame; out_first marks word 1.
- A one-word frame asserts out_first and out_last together.
- The length FIFO is popped on the out_last transfer.
REQ-019 Read and write share the RAM in the same cycle without stalls.
- Read only ever covers committed words.
- A rollback never moves wr_ptr behind the committed pointer.
REQ-020 Free-word count = 2^ADDR_W-1 minus (wr_ptr minus rd_ptr), computed modulo 2^ADDR_W; the buffer never holds more than 2^ADDR_W-1 words.

Reset
REQ-021 On rst:
- Write state <= IDLE.
- wr_ptr, committed pointer, rd_ptr <= 0.
- Length FIFO empty.
- out_valid, out_first, out_last <= 0.
- out_data, out_len <= 0.
- drop_cnt <= 0.
REQ-022 rst mid-frame or mid-readout discards all buffered frames; RAM contents are don't-care.

Verification
REQ-023 Scenario: LOCAL_MAC=48'h0A0B0C0D0E0F, frame with matching des_mac, len_type=16'd10, 6 data_valid words 1..6, done_flag.
- Required: 6 transfers with data 1..6.
- out_first on word 1, out_last on word 6, out_len=10.
- drop_cnt=0.
REQ-024 Scenario: des_mac=48'h112233445566, PROMISC=0.
- Required: no out_valid, drop_cnt=1.
- A following broadcast frame is delivered intact.
REQ-025 Scenario: ADDR_W=4, 20-word frame.
- Required: frame dropped, drop_cnt=1, no output.
- A following 3-word frame is delivered with correct data.
REQ-026 Scenario: five 2-word frames back-to-back with out_ready=0.
- Required: 4 committed frames, fifth dropped, drop_cnt=1.
- Raising out_ready yields 8 words in order.
REQ-027 Scenario: start_flag, 3 words, then start_flag again without done, 2 words, done.
- Required: only the 2-word frame is output, drop_cnt=1.
REQ-028 Scenario: out_ready toggled randomly during a 100-word frame, with rst pulsed once mid-readout.
- Required: no duplicated or skipped words before rst.
- Every output is 0 on the cycle after rst.
- Subsequent frames are delivered correctly.

Source files
------------

// File: rtl/ether_rx_frame_buf.sv
// Receive frame buffer: stores address-filtered Ethernet frames in a circular word RAM
// and streams complete frames out with first/last markers and the frame's len_type.
module ether_rx_frame_buf #(
    parameter logic [47:0] LOCAL_MAC = 48'h0000_0000_0000,
    parameter bit          PROMISC   = 1'b0,
    parameter int          ADDR_W    = 9
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic        start_flag,
    input  logic        des_mac_valid,
    input  logic [47:0] des_mac,
    input  logic        len_type_valid,
    input  logic [15:0] len_type,
    input  logic        data_valid,
    input  logic [31:0] data,
    input  logic        done_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_first,
    output logic        out_last,
    output logic [15:0] out_len,
    output logic [15:0] drop_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, FILL, DISCARD} wr_state_t;

    wr_state_t state, state_nxt;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, commit_ptr, rd_ptr, word_cnt, rd_pos;
    logic [15:0]       len_reg;

    logic [ADDR_W-1:0] lf_cnt [4];
    logic [15:0]       lf_len [4];
    logic [1:0]        lf_wr, lf_rd;
    logic [2:0]        lf_count;

    logic              mac_ok, buf_full, fifo_full;
    logic [ADDR_W-1:0] cnt_inc, head_cnt;
    logic [15:0]       len_cur;
    logic              wr_en, rollback, push, len_load, pop, fetch;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;

    assign mac_ok    = PROMISC || (des_mac == LOCAL_MAC) || (des_mac == {48{1'b1}});
    // One slot is always kept free so wr_ptr == rd_ptr unambiguously means empty.
    assign buf_full  = (wr_ptr + ADDR_W'(1)) == rd_ptr;
    assign fifo_full = (lf_count == 3'd4);
    assign cnt_inc   = word_cnt + ADDR_W'(data_valid);
    assign len_cur   = len_load ? len_type : len_reg;
    assign drop_sum  = {1'b0, drop_cnt} + 17'(drop_inc);

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DISCARD: begin
                if (start_flag) begin
                    state_nxt = fifo_full ? DISCARD : FILL;
                end else if (done_flag) begin
                    state_nxt = IDLE;
                end
            end
            FILL: begin
                if (start_flag) begin
                    state_nxt = fifo_full ? DISCARD : FILL;
                end else if (des_mac_valid && !mac_ok) begin
                    state_nxt = DISCARD;
                end else if (data_valid && buf_full) begin
                    state_nxt = DISCARD;
                end else if (done_flag) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A restart reuses the rollback path: wr_ptr returns to the committed pointer.
    always_comb begin
        wr_en    = 1'b0;
        rollback = 1'b0;
        push     = 1'b0;
        len_load = 1'b0;
        drop_inc = 2'd0;
        case (state)
            IDLE, DISCARD: begin
                if (start_flag) begin
                    rollback = 1'b1;
                    drop_inc = {1'b0, fifo_full};
                end
            end
            FILL: begin
                if (start_flag) begin
                    rollback = 1'b1;
                    drop_inc = fifo_full ? 2'd2 : 2'd1;
                end else if ((des_mac_valid && !mac_ok) || (data_valid && buf_full)) begin
                    rollback = 1'b1;
                    drop_inc = 2'd1;
                end else begin
                    wr_en    = data_valid;
                    len_load = len_type_valid;
                    if (done_flag) begin
                        if (cnt_inc != '0) begin
                            push = 1'b1;
                        end else begin
                            rollback = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            word_cnt   <= '0;
            len_reg    <= '0;
            drop_cnt   <= '0;
        end else begin
            if (rollback) begin
                wr_ptr   <= commit_ptr;
                word_cnt <= '0;
                len_reg  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr   <= wr_ptr + ADDR_W'(1);
                    word_cnt <= cnt_inc;
                end
                if (len_load) begin
                    len_reg <= len_type;
                end
                if (push) begin
                    commit_ptr <= wr_ptr + ADDR_W'(wr_en);
                    word_cnt   <= '0;
                end
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            lf_wr    <= '0;
            lf_rd    <= '0;
            lf_count <= '0;
        end else begin
            if (push) begin
                lf_cnt[lf_wr] <= cnt_inc;
                lf_len[lf_wr] <= len_cur;
                lf_wr         <= lf_wr + 2'd1;
            end
            if (pop) begin
                lf_rd <= lf_rd + 2'd1;
            end
            case ({push, pop})
                2'b10:   lf_count <= lf_count + 3'd1;
                2'b01:   lf_count <= lf_count - 3'd1;
                default: lf_count <= lf_count;
            endcase
        end
    end

    // rd_pos counts words of the head frame already moved into the output register.
    assign head_cnt = lf_cnt[lf_rd];
    assign pop      = out_valid && out_ready && out_last;
    assign fetch    = (lf_count != 3'd0) && (rd_pos != head_cnt) && (!out_valid || out_ready);

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            rd_pos    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_len   <= '0;
        end else if (fetch) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_ptr];
            out_first <= (rd_pos == '0);
            out_last  <= ((rd_pos + ADDR_W'(1)) == head_cnt);
            out_len   <= lf_len[lf_rd];
            rd_ptr    <= rd_ptr + ADDR_W'(1);
            rd_pos    <= rd_pos + ADDR_W'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (pop) begin
                rd_pos <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ether_rx_frame_buf.sv
// Randomised bench for ether_rx_frame_buf: a queue-based frame model predicts every
// delivered word and the drop count; a small-buffer instance covers overflow.
module tb_ether_rx_frame_buf;

    localparam logic [47:0] LOCAL = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER = 48'h1122_3344_5566;

    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        last;
        logic [15:0] len;
    } word_t;

    logic        rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_flag = 1'b0;
    logic        des_mac_valid = 1'b0;
    logic [47:0] des_mac = '0;
    logic        len_type_valid = 1'b0;
    logic [15:0] len_type = '0;
    logic        data_valid = 1'b0;
    logic [31:0] data = '0;
    logic        done_flag = 1'b0;
    logic        out_ready = 1'b1;
    logic        s_out_ready = 1'b1;

    logic        out_valid, out_first, out_last;
    logic [31:0] out_data;
    logic [15:0] out_len, drop_cnt;
    logic        s_out_valid, s_out_first, s_out_last;
    logic [31:0] s_out_data;
    logic [15:0] s_out_len, s_drop_cnt;

    word_t       exp_q[$];
    logic [33:0] small_got[$];
    int          n_checks = 0;
    int          n_fails = 0;
    int          exp_drops = 0;
    int          xfer_count = 0;
    int          ready_mode = 1;
    bit          in_fill = 1'b0;

    word_t       mon_word;
    bit          stall_prev = 1'b0;
    logic [31:0] held_data;
    logic [1:0]  held_flags;
    logic [15:0] held_len;

    always #5 rx_clk = ~rx_clk;

    ether_rx_frame_buf #(.LOCAL_MAC(LOCAL), .PROMISC(1'b0), .ADDR_W(9)) dut (
        .rx_clk(rx_clk), .rst(rst), .start_flag(start_flag),
        .des_mac_valid(des_mac_valid), .des_mac(des_mac),
        .len_type_valid(len_type_valid), .len_type(len_type),
        .data_valid(data_valid), .data(data), .done_flag(done_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .out_len(out_len),
        .drop_cnt(drop_cnt)
    );

    ether_rx_frame_buf #(.LOCAL_MAC(LOCAL), .PROMISC(1'b0), .ADDR_W(4)) dut_small (
        .rx_clk(rx_clk), .rst(rst), .start_flag(start_flag),
        .des_mac_valid(des_mac_valid), .des_mac(des_mac),
        .len_type_valid(len_type_valid), .len_type(len_type),
        .data_valid(data_valid), .data(data), .done_flag(done_flag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_first(s_out_first), .out_last(s_out_last), .out_len(s_out_len),
        .drop_cnt(s_drop_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge rx_clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1));
        endcase
    endtask

    function automatic int pendingFrames();
        int c = 0;
        foreach (exp_q[i]) if (exp_q[i].last) c++;
        return c;
    endfunction

    // Frame model: four outstanding frames at most, address filter, missed done drops.
    task automatic applyStimulus(input logic [47:0] mac, input logic [15:0] len, input int nwords,
                                 input logic [31:0] base, input bit with_done);
        bit accept;
        word_t w;
        if (in_fill) begin
            exp_drops++;
            in_fill = 1'b0;
        end
        accept = (pendingFrames() < 4);
        if (!accept) exp_drops++;
        if (accept && !(mac == LOCAL || mac == BCAST)) begin
            exp_drops++;
            accept = 1'b0;
        end
        in_fill = accept;

        start_flag = 1'b1; tick(); start_flag = 1'b0;
        des_mac = mac; des_mac_valid = 1'b1; tick(); des_mac_valid = 1'b0;
        len_type = len; len_type_valid = 1'b1; tick(); len_type_valid = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            if ($urandom_range(3) == 0) tick();
            data = base + 32'(i);
            data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
        end
        if (with_done) begin
            if (accept && nwords > 0) begin
                for (int i = 0; i < nwords; i++) begin
                    w.data  = base + 32'(i);
                    w.first = (i == 0);
                    w.last  = (i == nwords - 1);
                    w.len   = len;
                    exp_q.push_back(w);
                end
            end
            in_fill = 1'b0;
            done_flag = 1'b1; tick(); done_flag = 1'b0;
        end
        tick();
    endtask

    task automatic resetDut();
        rst = 1'b1;
        exp_q.delete();
        exp_drops = 0;
        in_fill = 1'b0;
        tick();
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_first", out_first, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_len", out_len, 0);
        checkOutput("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic waitDrain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    always @(negedge rx_clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, held_data);
                checkOutput("hold_flags", {out_first, out_last}, held_flags);
                checkOutput("hold_len", out_len, held_len);
            end
            if (exp_q.size() == 0) begin
                checkOutput("idle_valid", out_valid, 0);
            end else if (out_valid && out_ready) begin
                mon_word = exp_q.pop_front();
                checkOutput("xfer_data", out_data, mon_word.data);
                checkOutput("xfer_first", out_first, mon_word.first);
                checkOutput("xfer_last", out_last, mon_word.last);
                checkOutput("xfer_len", out_len, mon_word.len);
                xfer_count++;
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_flags = {out_first, out_last};
            held_len   = out_len;
        end
    end

    always @(negedge rx_clk) begin
        if (!rst && s_out_valid && s_out_ready) begin
            small_got.push_back({s_out_first, s_out_last, s_out_data});
        end
    end

    initial begin
        int x0;
        int t;
        int sel;
        logic [47:0] mac;

        // Single matching frame
        resetDut();
        x0 = xfer_count;
        applyStimulus(LOCAL, 16'd10, 6, 32'd1, 1'b1);
        waitDrain();
        checkOutput("s23_words", xfer_count - x0, 6);
        checkOutput("s23_drop", drop_cnt, 0);

        // Foreign address dropped, broadcast delivered
        resetDut();
        x0 = xfer_count;
        applyStimulus(OTHER, 16'h0800, 4, 32'h100, 1'b1);
        repeat (10) tick();
        checkOutput("s24_drop_a", drop_cnt, exp_drops);
        applyStimulus(BCAST, 16'h0806, 5, 32'h200, 1'b1);
        waitDrain();
        checkOutput("s24_words", xfer_count - x0, 5);
        checkOutput("s24_drop_b", drop_cnt, 1);

        // Oversized frame on the 16-word buffer
        resetDut();
        small_got.delete();
        applyStimulus(LOCAL, 16'd20, 20, 32'h300, 1'b1);
        waitDrain();
        checkOutput("s25_small_drop", s_drop_cnt, (20 > (1 << 4) - 1) ? 1 : 0);
        checkOutput("s25_small_none", small_got.size(), 0);
        applyStimulus(LOCAL, 16'd3, 3, 32'h400, 1'b1);
        waitDrain();
        checkOutput("s25_small_count", small_got.size(), 3);
        if (small_got.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("s25_small_word", small_got[i], {(i == 0), (i == 2), 32'h400 + 32'(i)});
            end
        end
        checkOutput("s25_small_len", s_out_len, 3);
        checkOutput("s25_main_drop", drop_cnt, exp_drops);

        // Length FIFO full while the consumer stalls
        resetDut();
        ready_mode = 0;
        tick();
        x0 = xfer_count;
        for (int f = 0; f < 5; f++) begin
            applyStimulus(LOCAL, 16'(f + 1), 2, 32'h500 + 32'(f * 16), 1'b1);
        end
        repeat (5) tick();
        checkOutput("s26_drop", drop_cnt, exp_drops);
        checkOutput("s26_stalled", out_valid, 1);
        ready_mode = 1;
        waitDrain();
        checkOutput("s26_words", xfer_count - x0, 8);

        // Missed done_flag
        resetDut();
        x0 = xfer_count;
        applyStimulus(LOCAL, 16'd7, 3, 32'h600, 1'b0);
        applyStimulus(LOCAL, 16'd8, 2, 32'h610, 1'b1);
        waitDrain();
        checkOutput("s27_words", xfer_count - x0, 2);
        checkOutput("s27_drop", drop_cnt, exp_drops);

        // Long frame with random backpressure, reset mid-readout, then random traffic
        resetDut();
        ready_mode = 2;
        x0 = xfer_count;
        applyStimulus(LOCAL, 16'd100, 100, 32'h1000, 1'b1);
        t = 0;
        while ((xfer_count - x0) < 30 && t < 1000) begin
            tick();
            t++;
        end
        if ((xfer_count - x0) < 30) checkOutput("s28_progress_timeout", xfer_count - x0, 30);
        resetDut();
        for (int k = 0; k < 20; k++) begin
            sel = int'($urandom_range(5));
            mac = (sel < 3) ? LOCAL : (sel < 5) ? BCAST : {16'h1234, 32'($urandom)};
            applyStimulus(mac, 16'($urandom), int'($urandom_range(12)), $urandom,
                          $urandom_range(7) != 0);
            waitDrain();
            checkOutput("rand_drop", drop_cnt, exp_drops);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
